hazard_controller: RTL and testbench
====================================

# hazard_controller

Pipeline sequencing controller for the five-stage core. It drives the enable and flush controls of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It resolves load-use hazards, control redirects, multi-cycle EX operations and data-memory wait states. It sits beside the datapath in the core top level; every pipeline register's enable comes from this block.

## Interface
Parameters:
- MAX_EX_CYCLES, 64, EX-wait watchdog limit in cycles; legal range 2..1024.

Ports (clock and reset):
- clk  in  1  core clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.

Hazard inputs:
- d_rs1, d_rs2  in  5  source registers of the instruction in ID.
- d_uses_rs1, d_uses_rs2  in  1  ID instruction reads rs1 / rs2.
- e_rd  in  5  destination register of the instruction in EX.
- e_is_load  in  1  EX instruction is a load.
- e_redirect  in  1  EX resolved a taken branch or jump.
- e_multi  in  1  EX instruction is a multi-cycle op (mul/div).
- ex_done  in  1  multi-cycle unit result valid (pulse).
- m_mem_req  in  1  MEM stage has an active data access.
- m_mem_ready  in  1  data memory completes the access this cycle.

Enable and flush outputs:
- f_enable  out  1  PC update enable.
- fd_enable, de_enable, em_enable, mw_enable  out  1  pipeline register enables.
- fd_flush, de_flush, em_flush  out  1  load a bubble (all-zero) into the register this cycle.

Status outputs:
- ex_start  out  1  one-cycle start pulse to the multi-cycle unit.
- ex_timeout  out  1  one-cycle pulse when the watchdog expires.
- stall_cycles  out  32  stall-cycle counter.
- redirect_count  out  32  redirect counter.

## Operation
- State machine: RUN, EX_WAIT.
- Default outputs in RUN with no hazard: all enables 1, all flushes 0, ex_start 0.

Memory wait (highest priority, any state):
- Condition: m_mem_req && !m_mem_ready.
- All enables are 0 and all flushes are 0, so the whole pipe freezes.
- State, the watchdog and any other request are held.

RUN state, in priority order:
- Multi-cycle op: e_multi. Drive ex_start=1, f_enable=fd_enable=de_enable=0, em_flush=1. Next state EX_WAIT, watchdog cleared.
- Redirect: e_redirect. Drive fd_flush=1, de_flush=1, f_enable=1. Any load-use stall is suppressed.
- Load-use: e_is_load && e_rd!=0 && ((d_uses_rs1 && d_rs1==e_rd) || (d_uses_rs2 && d_rs2==e_rd)). Drive f_enable=fd_enable=0 and de_flush=1 for exactly one cycle; no state change.

EX_WAIT state:
- Drive f_enable=fd_enable=de_enable=0 and em_flush=1, so bubbles enter MEM.
- e_redirect is ignored.
- ex_done, or a latched done_pending flag, moves the block to RUN. In the exit cycle, de_enable=em_enable=1 so the result advances, and em_flush=0.
- ex_done arriving during a memory wait sets done_pending. Exit occurs in the first cycle the memory wait clears; done_pending is cleared on exit.
- Watchdog: counts cycles in EX_WAIT that are not frozen by a memory wait. When the count reaches MAX_EX_CYCLES-1 without done, pulse ex_timeout and exit exactly as if done.

Reset:
- While reset is high: state=RUN, watchdog=0, done_pending=0, counters=0.
- Outputs during reset: all enables 0, fd_flush=de_flush=em_flush=1, ex_start=0, ex_timeout=0.
- Reset asserted in EX_WAIT abandons the operation; no ex_timeout is issued.

## Timing
- Outputs are combinational from the current state and current inputs; the state is registered.
- ex_start is asserted in the first cycle e_multi is seen in RUN only.
- ex_done is sampled only in EX_WAIT. The earliest exit is the cycle after ex_start.
- Load-use costs 1 bubble; a redirect costs 2 bubbles.
- A multi-cycle op costs N+1 stall cycles for done arriving N cycles after ex_start.

## Configuration
- Macro: HAZARD_PERF_CNT_EN.
- Defined:
  - stall_cycles increments every cycle fd_enable=0 outside reset.
  - redirect_count increments on each honoured redirect.
  - Both counters wrap at 2^32.
- Undefined: both outputs are tied to 0 and no counter flops are built. The port list is unchanged.

## Test plan
- Load-use: e_is_load=1, e_rd=5, d_rs1=5, d_uses_rs1=1 -> exactly one cycle of f_enable=fd_enable=0 and de_flush=1. Repeat with e_rd=0 -> no stall.
- Redirect plus load-use in the same cycle -> fd_flush=de_flush=1, f_enable=1, no stall; redirect_count +1 when the macro is defined.
- e_multi with ex_done 3 cycles after ex_start -> ex_start high 1 cycle, 4 stall cycles, exit with de_enable=em_enable=1.
- ex_done during a memory wait inside EX_WAIT -> pipeline frozen; exit in the first cycle m_mem_ready resolves the wait.
- MAX_EX_CYCLES=4, ex_done never asserted -> ex_timeout pulses on the 4th EX_WAIT cycle, then state RUN.
- Reset asserted mid EX_WAIT -> next cycle in RUN, counters 0, no ex_timeout.

Source files
------------

// File: rtl/hazard_controller.sv
// Pipeline sequencing controller: stalls, flushes and freezes the five-stage pipe.
// Optional perf counters are built only when HAZARD_PERF_CNT_EN is defined.
module hazard_controller #(
  parameter int MAX_EX_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  d_rs1,
  input  logic [4:0]  d_rs2,
  input  logic        d_uses_rs1,
  input  logic        d_uses_rs2,
  input  logic [4:0]  e_rd,
  input  logic        e_is_load,
  input  logic        e_redirect,
  input  logic        e_multi,
  input  logic        ex_done,
  input  logic        m_mem_req,
  input  logic        m_mem_ready,
  output logic        f_enable,
  output logic        fd_enable,
  output logic        de_enable,
  output logic        em_enable,
  output logic        mw_enable,
  output logic        fd_flush,
  output logic        de_flush,
  output logic        em_flush,
  output logic        ex_start,
  output logic        ex_timeout,
  output logic [31:0] stall_cycles,
  output logic [31:0] redirect_count
);
  localparam int WW = (MAX_EX_CYCLES > 2) ? $clog2(MAX_EX_CYCLES) : 1;
  localparam logic [WW-1:0] WD_LIM = WW'(MAX_EX_CYCLES - 1);

  typedef enum logic {RUN, EX_WAIT} state_e;

  state_e        state_q, state_d;
  logic [WW-1:0] wdog_q, wdog_d;
  logic          pend_q, pend_d;

  logic mem_wait, load_use, redir_take, ex_exit;

  assign mem_wait   = m_mem_req && !m_mem_ready;
  assign load_use   = e_is_load && (e_rd != 5'd0) &&
                      ((d_uses_rs1 && (d_rs1 == e_rd)) || (d_uses_rs2 && (d_rs2 == e_rd)));
  assign redir_take = !reset && !mem_wait && (state_q == RUN) && !e_multi && e_redirect;
  assign ex_exit    = ex_done || pend_q || (wdog_q == WD_LIM);

  always_comb begin
    f_enable   = 1'b1;
    fd_enable  = 1'b1;
    de_enable  = 1'b1;
    em_enable  = 1'b1;
    mw_enable  = 1'b1;
    fd_flush   = 1'b0;
    de_flush   = 1'b0;
    em_flush   = 1'b0;
    ex_start   = 1'b0;
    ex_timeout = 1'b0;
    state_d    = state_q;
    wdog_d     = wdog_q;
    pend_d     = pend_q;
    if (reset) begin
      {f_enable, fd_enable, de_enable, em_enable, mw_enable} = '0;
      {fd_flush, de_flush, em_flush} = 3'b111;
      state_d = RUN;
      wdog_d  = '0;
      pend_d  = 1'b0;
    end else if (mem_wait) begin
      // Whole pipe freezes; a done seen now is remembered for the release cycle.
      {f_enable, fd_enable, de_enable, em_enable, mw_enable} = '0;
      if ((state_q == EX_WAIT) && ex_done) pend_d = 1'b1;
    end else begin
      case (state_q)
        RUN: begin
          if (e_multi) begin
            ex_start  = 1'b1;
            f_enable  = 1'b0;
            fd_enable = 1'b0;
            de_enable = 1'b0;
            em_flush  = 1'b1;
            state_d   = EX_WAIT;
            wdog_d    = '0;
          end else if (redir_take) begin
            fd_flush = 1'b1;
            de_flush = 1'b1;
          end else if (load_use) begin
            f_enable  = 1'b0;
            fd_enable = 1'b0;
            de_flush  = 1'b1;
          end
        end
        EX_WAIT: begin
          f_enable  = 1'b0;
          fd_enable = 1'b0;
          if (ex_exit) begin
            // Result advances into MEM; a watchdog exit looks exactly like done.
            ex_timeout = !(ex_done || pend_q);
            state_d    = RUN;
            wdog_d     = '0;
            pend_d     = 1'b0;
          end else begin
            de_enable = 1'b0;
            em_flush  = 1'b1;
            wdog_d    = wdog_q + 1'b1;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      wdog_q  <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wdog_q  <= wdog_d;
      pend_q  <= pend_d;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_q, redir_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
      redir_q <= '0;
    end else begin
      if (!fd_enable) stall_q <= stall_q + 32'd1;
      if (redir_take) redir_q <= redir_q + 32'd1;
    end
  end

  assign stall_cycles   = stall_q;
  assign redirect_count = redir_q;
`else
  assign stall_cycles   = 32'd0;
  assign redirect_count = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller (MAX_EX_CYCLES=4) with hand-computed expectations.
module tb_hazard_controller;
  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  d_rs1, d_rs2, e_rd;
  logic        d_uses_rs1, d_uses_rs2, e_is_load, e_redirect, e_multi, ex_done;
  logic        m_mem_req, m_mem_ready;
  logic        f_enable, fd_enable, de_enable, em_enable, mw_enable;
  logic        fd_flush, de_flush, em_flush, ex_start, ex_timeout;
  logic [31:0] stall_cycles, redirect_count;

  int checks = 0;
  int failures = 0;
  int exp_stall = 0;
  int exp_redir = 0;

  always #5 clk = ~clk;

  hazard_controller #(.MAX_EX_CYCLES(4)) dut (
    .clk(clk), .reset(reset),
    .d_rs1(d_rs1), .d_rs2(d_rs2), .d_uses_rs1(d_uses_rs1), .d_uses_rs2(d_uses_rs2),
    .e_rd(e_rd), .e_is_load(e_is_load), .e_redirect(e_redirect), .e_multi(e_multi),
    .ex_done(ex_done), .m_mem_req(m_mem_req), .m_mem_ready(m_mem_ready),
    .f_enable(f_enable), .fd_enable(fd_enable), .de_enable(de_enable),
    .em_enable(em_enable), .mw_enable(mw_enable),
    .fd_flush(fd_flush), .de_flush(de_flush), .em_flush(em_flush),
    .ex_start(ex_start), .ex_timeout(ex_timeout),
    .stall_cycles(stall_cycles), .redirect_count(redirect_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    reset = 1'b0; d_rs1 = 5'd0; d_rs2 = 5'd0; d_uses_rs1 = 1'b0; d_uses_rs2 = 1'b0;
    e_rd = 5'd0; e_is_load = 1'b0; e_redirect = 1'b0; e_multi = 1'b0; ex_done = 1'b0;
    m_mem_req = 1'b0; m_mem_ready = 1'b0;
  endtask

  // en = {f,fd,de,em,mw}, fl = {fd,de,em}, st = {ex_start,ex_timeout}.
  // Counters are compared against what earlier cycles should have accumulated.
  task automatic step(input string tag, input logic [4:0] en, input logic [2:0] fl,
                      input logic [1:0] st);
    #1;
    chk({tag, ".en"}, 32'({f_enable, fd_enable, de_enable, em_enable, mw_enable}), 32'(en));
    chk({tag, ".fl"}, 32'({fd_flush, de_flush, em_flush}), 32'(fl));
    chk({tag, ".st"}, 32'({ex_start, ex_timeout}), 32'(st));
`ifdef HAZARD_PERF_CNT_EN
    chk({tag, ".stall"}, stall_cycles, 32'(exp_stall));
    chk({tag, ".redir"}, redirect_count, 32'(exp_redir));
`else
    chk({tag, ".stall"}, stall_cycles, 32'd0);
    chk({tag, ".redir"}, redirect_count, 32'd0);
`endif
    if (reset) begin
      exp_stall = 0;
      exp_redir = 0;
    end else begin
      if (!en[3]) exp_stall++;
      if (fl[2])  exp_redir++;
    end
    @(negedge clk);
  endtask

  initial begin
    idle();
    reset = 1'b1;
    @(negedge clk); @(negedge clk);
    step("reset", 5'b00000, 3'b111, 2'b00);
    idle();
    step("idle", 5'b11111, 3'b000, 2'b00);

    e_is_load = 1; e_rd = 5; d_rs1 = 5; d_uses_rs1 = 1;
    step("lu_rs1", 5'b00111, 3'b010, 2'b00);
    idle();
    step("lu_after", 5'b11111, 3'b000, 2'b00);
    e_is_load = 1; e_rd = 0; d_rs1 = 0; d_uses_rs1 = 1;
    step("lu_x0", 5'b11111, 3'b000, 2'b00);
    e_rd = 7; d_rs1 = 3; d_rs2 = 7; d_uses_rs2 = 1;
    step("lu_rs2", 5'b00111, 3'b010, 2'b00);
    d_uses_rs2 = 0;
    step("lu_nouse", 5'b11111, 3'b000, 2'b00);

    e_rd = 9; d_rs1 = 9; d_uses_rs1 = 1; e_redirect = 1;
    step("redir_lu", 5'b11111, 3'b110, 2'b00);
    idle();
    step("redir_after", 5'b11111, 3'b000, 2'b00);

    e_multi = 1;
    step("mc_start", 5'b00011, 3'b001, 2'b10);
    step("mc_w1", 5'b00011, 3'b001, 2'b00);
    e_redirect = 1;
    step("mc_w2_redir", 5'b00011, 3'b001, 2'b00);
    e_redirect = 0; ex_done = 1;
    step("mc_exit", 5'b00111, 3'b000, 2'b00);
    idle();
    step("mc_after", 5'b11111, 3'b000, 2'b00);

    e_multi = 1; m_mem_req = 1;
    step("mw_run_frz", 5'b00000, 3'b000, 2'b00);
    m_mem_req = 0;
    step("mw_start", 5'b00011, 3'b001, 2'b10);
    m_mem_req = 1; ex_done = 1;
    step("mw_done_frz", 5'b00000, 3'b000, 2'b00);
    ex_done = 0;
    step("mw_frz2", 5'b00000, 3'b000, 2'b00);
    m_mem_ready = 1;
    step("mw_exit", 5'b00111, 3'b000, 2'b00);
    idle();
    step("mw_after", 5'b11111, 3'b000, 2'b00);

    e_multi = 1;
    step("to_start", 5'b00011, 3'b001, 2'b10);
    step("to_w1", 5'b00011, 3'b001, 2'b00);
    m_mem_req = 1;
    step("to_frz", 5'b00000, 3'b000, 2'b00);
    m_mem_req = 0;
    step("to_w2", 5'b00011, 3'b001, 2'b00);
    step("to_w3", 5'b00011, 3'b001, 2'b00);
    step("to_w4", 5'b00111, 3'b000, 2'b01);
    e_multi = 0;
    step("to_after", 5'b11111, 3'b000, 2'b00);

    e_multi = 1;
    step("rs_start", 5'b00011, 3'b001, 2'b10);
    step("rs_w1", 5'b00011, 3'b001, 2'b00);
    reset = 1;
    step("rs_reset", 5'b00000, 3'b111, 2'b00);
    reset = 0;
    step("rs_run", 5'b00011, 3'b001, 2'b10);
    step("rs_w1b", 5'b00011, 3'b001, 2'b00);
    idle(); ex_done = 1;
    step("rs_exit", 5'b00111, 3'b000, 2'b00);
    idle();
    step("rs_after", 5'b11111, 3'b000, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
